// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card SPI command transfer engine.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CMD_TX     = 3'd1,
        ST_NCR_WAIT   = 3'd2,
        ST_RESP_RX    = 3'd3,
        ST_TOKEN_WAIT = 3'd4,
        ST_DATA_RX    = 3'd5,
        ST_CRC_RX     = 3'd6,
        ST_NEC        = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        STAT_OK            = 3'd0,
        STAT_NCR_TIMEOUT   = 3'd1,
        STAT_R1_ERR        = 3'd2,
        STAT_TOKEN_ERR     = 3'd3,
        STAT_TOKEN_TIMEOUT = 3'd4,
        STAT_CRC_ERR       = 3'd5
    } status_e;

    localparam logic [7:0] CMD_PREFIX  = 8'h40;
    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] FILL_BYTE   = 8'hFF;

endpackage

// File: rtl/sd_spi_byte.sv
// One full-duplex SPI mode-0 byte: mosi changes on sclk fall, miso sampled on sclk rise, MSB first.
module sd_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       rx_done,
    output logic       byte_end,
    output logic [7:0] rx_byte
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = $clog2(HALF + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

    logic          active_r;
    logic [DW-1:0] div_cnt_r;
    logic [3:0]    ph_r;
    logic [7:0]    tx_sr_r;
    logic [7:0]    rx_sr_r;

    // Half-period sequencer: even phases end in a rising edge, odd phases in a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_r  <= 1'b0;
            div_cnt_r <= '0;
            ph_r      <= 4'd0;
            tx_sr_r   <= 8'hFF;
            rx_sr_r   <= 8'h00;
            rx_byte   <= 8'h00;
            rx_done   <= 1'b0;
            byte_end  <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b1;
        end else begin
            rx_done  <= 1'b0;
            byte_end <= 1'b0;
            if (!active_r) begin
                if (go) begin
                    active_r  <= 1'b1;
                    tx_sr_r   <= tx_byte;
                    mosi      <= tx_byte[7];
                    div_cnt_r <= '0;
                    ph_r      <= 4'd0;
                end
            end else if (div_cnt_r != DIV_LAST) begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end else begin
                div_cnt_r <= '0;
                ph_r      <= ph_r + 4'd1;
                if (!ph_r[0]) begin
                    sclk    <= 1'b1;
                    rx_sr_r <= {rx_sr_r[6:0], miso};
                    if (ph_r == 4'd14) begin
                        rx_byte <= {rx_sr_r[6:0], miso};
                        rx_done <= 1'b1;
                    end
                end else begin
                    // Shift in ones so mosi idles high after the last bit.
                    sclk    <= 1'b0;
                    tx_sr_r <= {tx_sr_r[6:0], 1'b1};
                    mosi    <= tx_sr_r[6];
                    if (ph_r == 4'd15) begin
                        active_r <= 1'b0;
                        byte_end <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sd_spi_cmd_xfer.sv
// SD SPI-mode command engine: sends a 6-byte command, collects R1, optional R3/R7 tail and one read block.
module sd_spi_cmd_xfer
    import sd_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int BLOCK_BYTES   = 512,
    parameter int NCR_MAX       = 8,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_extra,
    input  logic        data_rd,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status,
    output logic [7:0]  r1,
    output logic [31:0] resp_word,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam logic [15:0] NCR_LAST   = 16'(NCR_MAX - 1);
    localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT - 1);
    localparam logic [15:0] BLOCK_LAST = 16'(BLOCK_BYTES - 1);

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e      state_r;
    logic [39:0] frame_r;
    logic [7:0]  tx_r;
    logic        go_r;
    logic        resp_extra_r;
    logic        data_rd_r;
    logic        finish_r;
    logic [15:0] cnt_r;
    logic [15:0] crc16_r;
    logic [7:0]  rx_crc_r;

    logic [7:0]  cmd_byte_s;
    logic [6:0]  crc7_s;
    logic        rx_done_s;
    logic        byte_end_s;
    logic [7:0]  rx_byte_s;

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go_r),
        .tx_byte  (tx_r),
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .rx_done  (rx_done_s),
        .byte_end (byte_end_s),
        .rx_byte  (rx_byte_s)
    );

    // Command byte and its CRC7 from the live inputs, captured only on accept.
    always_comb begin
        cmd_byte_s = CMD_PREFIX | {2'b00, cmd_index};
        crc7_s     = crc7_40({cmd_byte_s, cmd_arg});
    end

    // Transaction sequencer: launches bytes on byte_end, interprets them on rx_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            frame_r      <= 40'h0;
            tx_r         <= FILL_BYTE;
            go_r         <= 1'b0;
            resp_extra_r <= 1'b0;
            data_rd_r    <= 1'b0;
            finish_r     <= 1'b0;
            cnt_r        <= 16'h0;
            crc16_r      <= 16'h0;
            rx_crc_r     <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            status       <= STAT_OK;
            r1           <= 8'hFF;
            resp_word    <= 32'h0;
            rd_data      <= 8'h00;
            rd_valid     <= 1'b0;
            cs_n         <= 1'b1;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            go_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r      <= ST_CMD_TX;
                        tx_r         <= cmd_byte_s;
                        frame_r      <= {cmd_arg, crc7_s, 1'b1};
                        resp_extra_r <= resp_extra;
                        data_rd_r    <= data_rd;
                        finish_r     <= 1'b0;
                        cnt_r        <= 16'h0;
                        go_r         <= 1'b1;
                        cs_n         <= 1'b0;
                        busy         <= 1'b1;
                        status       <= STAT_OK;
                        r1           <= 8'hFF;
                        resp_word    <= 32'h0;
                    end
                end
                default: begin
                    if (byte_end_s) begin
                        if (finish_r) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cs_n    <= 1'b1;
                        end else begin
                            go_r <= 1'b1;
                            if (state_r == ST_CMD_TX) begin
                                tx_r    <= frame_r[39:32];
                                frame_r <= {frame_r[31:0], 8'h00};
                            end else begin
                                tx_r <= FILL_BYTE;
                            end
                        end
                    end
                    if (rx_done_s) begin
                        case (state_r)
                            ST_CMD_TX: begin
                                if (cnt_r == 16'd5) begin
                                    state_r <= ST_NCR_WAIT;
                                    cnt_r   <= 16'h0;
                                end else begin
                                    cnt_r <= sat_inc(cnt_r);
                                end
                            end
                            ST_NCR_WAIT: begin
                                cnt_r <= 16'h0;
                                if (!rx_byte_s[7]) begin
                                    r1 <= rx_byte_s;
                                    if (rx_byte_s != 8'h00 && rx_byte_s != 8'h01) begin
                                        status  <= STAT_R1_ERR;
                                        state_r <= ST_NEC;
                                    end else if (resp_extra_r) begin
                                        state_r <= ST_RESP_RX;
                                    end else if (data_rd_r) begin
                                        state_r <= ST_TOKEN_WAIT;
                                    end else begin
                                        state_r <= ST_NEC;
                                    end
                                end else if (cnt_r >= NCR_LAST) begin
                                    status  <= STAT_NCR_TIMEOUT;
                                    state_r <= ST_NEC;
                                end else begin
                                    cnt_r <= sat_inc(cnt_r);
                                end
                            end
                            ST_RESP_RX: begin
                                resp_word <= {resp_word[23:0], rx_byte_s};
                                if (cnt_r == 16'd3) begin
                                    cnt_r   <= 16'h0;
                                    state_r <= data_rd_r ? ST_TOKEN_WAIT : ST_NEC;
                                end else begin
                                    cnt_r <= sat_inc(cnt_r);
                                end
                            end
                            ST_TOKEN_WAIT: begin
                                cnt_r <= 16'h0;
                                if (rx_byte_s == START_TOKEN) begin
                                    crc16_r <= 16'h0;
                                    state_r <= ST_DATA_RX;
                                end else if (rx_byte_s[7:4] == 4'h0) begin
                                    status  <= STAT_TOKEN_ERR;
                                    state_r <= ST_NEC;
                                end else if (cnt_r >= TOKEN_LAST) begin
                                    status  <= STAT_TOKEN_TIMEOUT;
                                    state_r <= ST_NEC;
                                end else begin
                                    cnt_r <= sat_inc(cnt_r);
                                end
                            end
                            ST_DATA_RX: begin
                                rd_data  <= rx_byte_s;
                                rd_valid <= 1'b1;
                                crc16_r  <= crc16_byte(crc16_r, rx_byte_s);
                                if (cnt_r >= BLOCK_LAST) begin
                                    cnt_r   <= 16'h0;
                                    state_r <= ST_CRC_RX;
                                end else begin
                                    cnt_r <= sat_inc(cnt_r);
                                end
                            end
                            ST_CRC_RX: begin
                                if (cnt_r == 16'h0) begin
                                    rx_crc_r <= rx_byte_s;
                                    cnt_r    <= 16'd1;
                                end else begin
                                    if ({rx_crc_r, rx_byte_s} != crc16_r) begin
                                        status <= STAT_CRC_ERR;
                                    end
                                    cnt_r   <= 16'h0;
                                    state_r <= ST_NEC;
                                end
                            end
                            ST_NEC: begin
                                finish_r <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                                busy    <= 1'b0;
                                cs_n    <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/sd_spi_cmd_xfer.md
SD_SPI_CMD_XFER -- requirements
Module: sd_spi_cmd_xfer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk period (even, >=2).
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, data-block payload bytes (1..4096).
REQ-003 SHALL have parameter NCR_MAX, default 8, max poll bytes awaiting R1.
REQ-004 SHALL have parameter TOKEN_TIMEOUT, default 1024, max poll bytes awaiting start token.
REQ-005 SHALL have ports, one per line (name  direction  width  meaning):
 clk  in  1  system clock, all logic rising-edge;
 reset_n  in  1  asynchronous active-low reset;
 start  in  1  begin transaction, sampled only when busy=0;
 cmd_index  in  6  command number (0x40 prefix added internally);
 cmd_arg  in  32  command argument;
 resp_extra  in  1  expect 4 trailing response bytes (R3/R7);
 data_rd  in  1  expect a single read data block after R1;
 busy  out  1  transaction in progress;
 done  out  1  one-cycle completion pulse;
 status  out  3  completion code (sd_pkg status enum);
 r1  out  8  captured R1 byte;
 resp_word  out  32  trailing response bytes, first received in [31:24];
 rd_data  out  8  received payload byte;
 rd_valid  out  1  one-cycle strobe per payload byte;
 sclk, cs_n, mosi  out  1 each  SPI lines;  miso  in  1  SPI data from card.

Function
REQ-006 SHALL run SPI mode 0: sclk idles low, mosi updated on sclk falling edge (CLK_DIV/2 clk after rise), miso sampled at sclk rising edge, MSB first.
REQ-007 SHALL accept start only in IDLE; start while busy SHALL be ignored; busy SHALL rise the cycle after accepted start.
REQ-008 SHALL latch cmd_index, cmd_arg, resp_extra, data_rd at accept; later input changes SHALL have no effect.
REQ-009 SHALL hold cs_n low from first CMD_TX bit until end of trailing NEC byte, high otherwise.
REQ-010 SHALL send frame {0x40|cmd_index, cmd_arg[31:24..7:0], {crc7,1'b1}}, crc7 computed internally (poly x^7+x^3+1, init 0) over first 5 bytes.
REQ-011 SHALL transmit 0xFF on mosi in every non-CMD_TX byte.
REQ-012 States: IDLE -> CMD_TX (6 bytes) -> NCR_WAIT -> [RESP_RX (4 bytes)] -> [TOKEN_WAIT -> DATA_RX (BLOCK_BYTES) -> CRC_RX (2 bytes)] -> NEC (1 byte) -> IDLE.
REQ-013 NCR_WAIT: first byte with bit7=0 SHALL be captured into r1; NCR_MAX bytes all with bit7=1 -> status NCR_TIMEOUT, go NEC.
REQ-014 r1 other than 0x00/0x01 -> status R1_ERR, skip RESP_RX/data phases, go NEC.
REQ-015 TOKEN_WAIT: 0xFE -> DATA_RX; byte with [7:4]=0000 -> status TOKEN_ERR, go NEC; TOKEN_TIMEOUT bytes of 0xFF -> status TOKEN_TIMEOUT, go NEC.
REQ-016 DATA_RX SHALL pulse rd_valid with rd_data on the clk after each byte's 8th sample; exactly BLOCK_BYTES strobes.
REQ-017 CRC16-CCITT (poly 0x1021, init 0) SHALL be accumulated over payload; mismatch with received CRC -> status CRC_ERR.
REQ-018 done SHALL pulse one cycle on NEC->IDLE with busy falling same cycle; status, r1, resp_word SHALL hold until next accepted start.
REQ-019 Status codes: OK=0, NCR_TIMEOUT=1, R1_ERR=2, TOKEN_ERR=3, TOKEN_TIMEOUT=4, CRC_ERR=5.
REQ-020 Byte and timeout counters SHALL saturate, never wrap; BLOCK_BYTES=1 and data_rd=0 SHALL be legal.

Reset
REQ-021 On reset_n low, immediately: state IDLE, busy=0, done=0, rd_valid=0, status=0, r1=0xFF, resp_word=0, rd_data=0, sclk=0, cs_n=1, mosi=1.
REQ-022 Reset mid-transaction SHALL abort without done pulse; next start after release SHALL run a full fresh transaction.

Structure
REQ-023 Package sd_pkg SHALL hold state enum, status enum, constants CMD_PREFIX=0x40, START_TOKEN=0xFE, FILL_BYTE=0xFF.
REQ-024 Sub-module sd_spi_byte SHALL perform one 8-bit full-duplex shift with sclk timing from CLK_DIV; CRC7/CRC16 inline in top.

Verification
REQ-025 CMD0 arg 0, card R1=0x01 after 2 fill bytes -> mosi 40 00 00 00 00 95, r1=0x01, status OK, one done.
REQ-026 CMD8 arg 0x000001AA, resp_extra=1, card 01 00 00 01 AA -> CRC byte 0x87, resp_word=0x000001AA, status OK.
REQ-027 CMD17 data_rd=1, BLOCK_BYTES=4, card 00, FF FF FE, DE AD BE EF, valid CRC16 -> 4 rd_valid with DE AD BE EF, status OK; corrupted CRC -> status CRC_ERR.
REQ-028 miso held 1 -> status NCR_TIMEOUT after NCR_MAX bytes; r1=0x04 -> R1_ERR, no rd_valid.
REQ-029 Token 0x08 -> TOKEN_ERR; start pulse mid-transaction ignored; reset_n low in DATA_RX -> cs_n=1 same cycle, no done.
